// File: rtl/complementarium_seq.sv
// Purpose : multi-cycle two's-complement negate / abs / ones'-complement / pass unit, CHUNK bits per cycle.
// Latency : accept at edge T, out_valid from edge T+N (N = WIDTH/CHUNK); one op per N+2 cycles at best.
// Backpressure : DONE holds result and overflow until out_ready; in_ready is low outside IDLE.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake; in_ready high only in IDLE
//   in_data[WIDTH]        operand (two's complement)
//   in_op[2]              00 pass, 01 negate, 10 abs, 11 ones' complement
//   out_valid/out_ready   result handshake
//   out_data[WIDTH]       result
//   out_ovf               negate/abs of the most negative value
module complementarium_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  // WIDTH must be a multiple of CHUNK; N = 1 collapses to a single CALC beat.
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_NEG  = 2'b01;
  localparam logic [1:0] OP_ABS  = 2'b10;
  localparam logic [1:0] OP_NOT  = 2'b11;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Captured operand and per-operation control.
  logic [WIDTH-1:0] opnd;
  logic             inv;
  logic             carry;
  logic             ovf_pend;
  logic [CW-1:0]    beat;

  // Decode of the operation offered on the input side.
  logic accept;
  logic acc_inv;
  logic acc_carry0;
  logic acc_ovf;

  // Slice datapath.
  logic             last_beat;
  int               base;
  logic [CHUNK-1:0] d_slice;
  logic [CHUNK-1:0] d_cond;
  logic [CHUNK:0]   sum;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_beat) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // in_ready stays low here, so an in_valid coinciding with the output
        // handshake is not taken until the following IDLE cycle.
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operation decode at accept time
  // ---------------------------------------------------------------------------
  always_comb begin
    accept     = in_valid & in_ready;
    // abs only complements when the operand is negative; otherwise it is pass.
    acc_inv    = (in_op == OP_NEG) | (in_op == OP_NOT) |
                 ((in_op == OP_ABS) & in_data[WIDTH-1]);
    acc_carry0 = (in_op == OP_NEG) | ((in_op == OP_ABS) & in_data[WIDTH-1]);
    // Only the +1 modes can overflow, and only on the most negative value,
    // which wraps back to itself.
    acc_ovf    = acc_carry0 & (in_data == MIN_VAL);
  end

  // ---------------------------------------------------------------------------
  // Slice datapath: one CHUNK-wide add per CALC beat, carry kept in a register
  // ---------------------------------------------------------------------------
  always_comb begin
    last_beat = (beat == CW'(N - 1));
    base      = int'(beat) * CHUNK;
    d_slice   = opnd[base +: CHUNK];
    d_cond    = inv ? ~d_slice : d_slice;
    sum       = {1'b0, d_cond} + {{CHUNK{1'b0}}, carry};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opnd     <= '0;
      inv      <= 1'b0;
      carry    <= 1'b0;
      ovf_pend <= 1'b0;
      beat     <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opnd     <= in_data;
            inv      <= acc_inv;
            carry    <= acc_carry0;
            ovf_pend <= acc_ovf;
            beat     <= '0;
          end
        end
        CALC: begin
          out_data[base +: CHUNK] <= sum[CHUNK-1:0];
          if (last_beat) begin
            // Carry out of the top slice is dropped (e.g. negate of 0).
            carry   <= 1'b0;
            beat    <= '0;
            out_ovf <= ovf_pend;
          end else begin
            carry <= sum[CHUNK];
            beat  <= beat + CW'(1);
          end
        end
        default: begin
          // DONE: result and flag held until the consumer takes them.
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interface invariants
  // ---------------------------------------------------------------------------
  a_hold_done: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_ovf)));

  a_excl_rdy_vld: assert property (@(posedge clk) disable iff (rst)
    !(in_ready && out_valid));

  // OP_PASS is the all-zero decode; named for readability of the table above.
  logic unused_pass;
  assign unused_pass = (in_op == OP_PASS);

endmodule

// File: tb/tb_complementarium_seq.sv
// Purpose : directed and randomised checks of complementarium_seq in four width/chunk configurations.
// Latency : n/a (testbench).
// Backpressure : bench drives out_ready low/random to exercise DONE holding.
module tb_complementarium_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  iv;
  logic [3:0]  ordy;
  logic [63:0] din;
  logic [1:0]  dop;

  logic ir0, ir1, ir2, ir3;
  logic ov0, ov1, ov2, ov3;
  logic of0, of1, of2, of3;
  logic [63:0] od0, od1, od2;
  logic [31:0] od3;

  // sel 0: W64/C16 (N=4)  sel 1: W64/C64 (N=1)  sel 2: W64/C8 (N=8)  sel 3: W32/C8 (N=4)
  complementarium_seq #(.WIDTH(64), .CHUNK(16)) u_w64c16 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0), .in_data(din), .in_op(dop),
    .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0), .out_ovf(of0));
  complementarium_seq #(.WIDTH(64), .CHUNK(64)) u_w64c64 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1), .in_data(din), .in_op(dop),
    .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1), .out_ovf(of1));
  complementarium_seq #(.WIDTH(64), .CHUNK(8)) u_w64c8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir2), .in_data(din), .in_op(dop),
    .out_valid(ov2), .out_ready(ordy[2]), .out_data(od2), .out_ovf(of2));
  complementarium_seq #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir3), .in_data(din[31:0]), .in_op(dop),
    .out_valid(ov3), .out_ready(ordy[3]), .out_data(od3), .out_ovf(of3));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic get_ir(input int sel);
    case (sel)
      0: return ir0;
      1: return ir1;
      2: return ir2;
      default: return ir3;
    endcase
  endfunction

  function automatic logic get_ov(input int sel);
    case (sel)
      0: return ov0;
      1: return ov1;
      2: return ov2;
      default: return ov3;
    endcase
  endfunction

  function automatic logic get_of(input int sel);
    case (sel)
      0: return of0;
      1: return of1;
      2: return of2;
      default: return of3;
    endcase
  endfunction

  function automatic logic [63:0] get_od(input int sel);
    case (sel)
      0: return od0;
      1: return od1;
      2: return od2;
      default: return {32'h0, od3};
    endcase
  endfunction

  function automatic int get_w(input int sel);
    return (sel == 3) ? 32 : 64;
  endfunction

  // Reference behaviour: {ovf, result} for an operand truncated to w bits.
  function automatic logic [64:0] model(input logic [63:0] x_in, input logic [1:0] op, input int w);
    logic [63:0] mask;
    logic [63:0] x;
    logic [63:0] mn;
    logic [63:0] neg;
    logic [63:0] r;
    logic        ovf;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    x    = x_in & mask;
    mn   = 64'd1 << (w - 1);
    neg  = (~x + 64'd1) & mask;
    case (op)
      2'b00: r = x;
      2'b01: r = neg;
      2'b10: r = ((x & mn) != 64'd0) ? neg : x;
      default: r = ~x & mask;
    endcase
    ovf = ((op == 2'b01) || (op == 2'b10)) && (x == mn);
    return {ovf, r};
  endfunction

  // One complete transaction with hand-computed expectations.
  task automatic do_op(input int sel, input logic [63:0] d, input logic [1:0] op, input string tag,
                       input logic [63:0] exp_d, input logic exp_o, input int exp_lat);
    int cyc;
    @(posedge clk); #1;
    din = d; dop = op; iv[sel] = 1'b1;
    cyc = 0;
    while (!get_ir(sel) && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_in_ready"}, 64'(get_ir(sel)), 64'd1);
    @(posedge clk); #1;                       // accept edge
    iv[sel] = 1'b0; din = ~d; dop = ~op;      // later input changes must be ignored
    cyc = 0;
    while (!get_ov(sel) && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_data"}, get_od(sel), exp_d);
    check({tag, "_ovf"}, 64'(get_of(sel)), 64'(exp_o));
    ordy[sel] = 1'b1;
    @(posedge clk); #1;
    ordy[sel] = 1'b0;
    check({tag, "_post"}, 64'({get_ov(sel), get_ir(sel)}), 64'b01);
  endtask

  // Random handshakes with an in-order scoreboard.
  task automatic rand_run(input int sel, input int count, input logic rand_op, input string tag);
    logic [64:0] q[$];
    logic [64:0] e;
    logic [63:0] nd;
    logic [1:0]  nop;
    int acc;
    int done;
    int cyc;
    acc = 0; done = 0; cyc = 0;
    nd  = {$urandom, $urandom};
    nop = rand_op ? 2'($urandom_range(0, 3)) : 2'b01;
    @(posedge clk); #1;
    din = nd; dop = nop;
    iv[sel]   = 1'($urandom_range(0, 1));
    ordy[sel] = 1'($urandom_range(0, 1));
    while (done < count && cyc < 20000) begin
      @(negedge clk);
      if (get_ov(sel) && ordy[sel]) begin
        if (q.size() == 0) begin
          check({tag, "_spurious"}, 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check({tag, "_data"}, get_od(sel), e[63:0]);
          check({tag, "_ovf"}, 64'(get_of(sel)), 64'(e[64]));
        end
        done++;
      end
      if (iv[sel] && get_ir(sel)) begin
        q.push_back(model(nd, nop, get_w(sel)));
        acc++;
        nd  = {$urandom, $urandom};
        nop = rand_op ? 2'($urandom_range(0, 3)) : 2'b01;
      end
      @(posedge clk); #1;
      din = nd; dop = nop;
      iv[sel]   = (acc < count) ? 1'($urandom_range(0, 1)) : 1'b0;
      ordy[sel] = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    iv[sel] = 1'b0; ordy[sel] = 1'b0;
    check({tag, "_results"}, 64'(done), 64'(count));
    check({tag, "_accepted"}, 64'(acc), 64'(count));
    check({tag, "_leftover"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] rnd;
    logic [63:0] held;
    int bad;
    iv = '0; ordy = '0; din = '0; dop = '0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state for every configuration.
    for (int s = 0; s < 4; s++) begin
      check($sformatf("rst%0d_in_ready", s), 64'(get_ir(s)), 64'd1);
      check($sformatf("rst%0d_out_valid", s), 64'(get_ov(s)), 64'd0);
      check($sformatf("rst%0d_out_data", s), get_od(s), 64'd0);
      check($sformatf("rst%0d_out_ovf", s), 64'(get_of(s)), 64'd0);
    end

    // Main configuration, directed.
    do_op(0, 64'h0000_0000_0000_0001, 2'b01, "neg1",     64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4);
    do_op(0, 64'h0000_0000_0001_0000, 2'b01, "neg_ripl", 64'hFFFF_FFFF_FFFF_0000, 1'b0, 4);
    do_op(0, 64'h0000_0000_0000_0000, 2'b01, "neg0",     64'h0000_0000_0000_0000, 1'b0, 4);
    do_op(0, 64'h8000_0000_0000_0000, 2'b01, "neg_min",  64'h8000_0000_0000_0000, 1'b1, 4);
    do_op(0, 64'h8000_0000_0000_0000, 2'b10, "abs_min",  64'h8000_0000_0000_0000, 1'b1, 4);
    do_op(0, 64'h8000_0000_0000_0000, 2'b11, "not_min",  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 4);
    do_op(0, 64'hFFFF_FFFF_FFFF_FFFB, 2'b10, "abs_m5",    64'h0000_0000_0000_0005, 1'b0, 4);
    do_op(0, 64'h0000_0000_0000_0005, 2'b10, "abs_p5",    64'h0000_0000_0000_0005, 1'b0, 4);
    do_op(0, 64'h0123_4567_89AB_CDEF, 2'b00, "pass_k",    64'h0123_4567_89AB_CDEF, 1'b0, 4);
    do_op(0, 64'h0F0F_0000_FFFF_1234, 2'b11, "not_k",     64'hF0F0_FFFF_0000_EDCB, 1'b0, 4);
    do_op(0, 64'hFFFF_FFFF_0000_0000, 2'b01, "neg_hi",    64'h0000_0001_0000_0000, 1'b0, 4);
    rnd = {$urandom, $urandom};
    do_op(0, rnd, 2'b00, "pass_rnd", rnd, 1'b0, 4);

    // Backpressure: DONE holds with out_ready low, in_valid pending is ignored.
    @(posedge clk); #1;
    din = 64'h0000_0000_0000_1234; dop = 2'b01; iv[0] = 1'b1;
    @(posedge clk); #1;                       // accepted (IDLE after previous op)
    din = 64'hDEAD_BEEF_0000_0001; dop = 2'b00;
    bad = 0;
    while (!ov0 && bad < 50) begin
      @(posedge clk); #1; bad++;
    end
    check("bp_lat", 64'(bad), 64'd4);
    held = od0;
    check("bp_data", held, 64'hFFFF_FFFF_FFFF_EDCC);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (od0 !== held || ir0 !== 1'b0 || ov0 !== 1'b1) bad++;
    end
    check("bp_hold", 64'(bad), 64'd0);
    ordy[0] = 1'b1;
    @(posedge clk); #1;                       // handshake with in_valid still high
    ordy[0] = 1'b0;
    check("bp_no_accept", 64'({ov0, ir0}), 64'b01);
    iv[0] = 1'b0;
    @(posedge clk); #1;
    check("bp_idle", 64'(ir0), 64'd1);

    // Reset during CALC beat 2: the operation vanishes.
    @(posedge clk); #1;
    din = 64'd1; dop = 2'b01; iv[0] = 1'b1;
    @(posedge clk); #1;                       // accept
    iv[0] = 1'b0;
    @(posedge clk);                           // beat 0
    @(posedge clk); #1;                       // beat 1
    rst = 1'b1;
    @(posedge clk); #1;                       // would have been beat 2
    rst = 1'b0;
    check("rstc_out_valid", 64'(ov0), 64'd0);
    check("rstc_out_data", od0, 64'd0);
    check("rstc_in_ready", 64'(ir0), 64'd1);
    check("rstc_out_ovf", 64'(of0), 64'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov0) bad++;
    end
    check("rstc_no_result", 64'(bad), 64'd0);

    // Other configurations, directed.
    do_op(1, 64'h0000_0000_0000_0001, 2'b01, "c64_neg1",   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
    do_op(1, 64'h8000_0000_0000_0000, 2'b01, "c64_negmin", 64'h8000_0000_0000_0000, 1'b1, 1);
    do_op(1, 64'hFFFF_FFFF_FFFF_FFFB, 2'b10, "c64_abs",    64'h0000_0000_0000_0005, 1'b0, 1);
    do_op(2, 64'h0000_0000_0000_0100, 2'b01, "c8_neg",     64'hFFFF_FFFF_FFFF_FF00, 1'b0, 8);
    do_op(2, 64'h8000_0000_0000_0000, 2'b10, "c8_absmin",  64'h8000_0000_0000_0000, 1'b1, 8);
    do_op(3, 64'h0000_0000_0000_0001, 2'b01, "w32_neg1",   64'h0000_0000_FFFF_FFFF, 1'b0, 4);
    do_op(3, 64'h0000_0000_8000_0000, 2'b01, "w32_negmin", 64'h0000_0000_8000_0000, 1'b1, 4);
    do_op(3, 64'hFFFF_FFFF_FFFF_FFFB, 2'b10, "w32_abs",    64'h0000_0000_0000_0005, 1'b0, 4);
    do_op(3, 64'h0000_0000_8000_0000, 2'b11, "w32_not",    64'h0000_0000_7FFF_FFFF, 1'b0, 4);

    // Random regressions with toggling handshakes.
    rand_run(0, 1000, 1'b0, "rnd_c16");
    rand_run(1, 200, 1'b0, "rnd_c64");
    rand_run(2, 200, 1'b0, "rnd_c8");
    rand_run(3, 200, 1'b0, "rnd_w32");
    rand_run(0, 200, 1'b1, "rnd_c16_ops");
    rand_run(3, 200, 1'b1, "rnd_w32_ops");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/complementarium_seq.md
# complementarium_seq

Parametrised, multi-cycle successor to the fixed 64-bit combinational two's-complement negator. It accepts a WIDTH-bit operand with a mode code over a valid/ready handshake and processes it in CHUNK-bit slices, one slice per cycle, rippling the carry between slices through a register. It returns the result and an overflow flag over a second valid/ready handshake. It sits between operand producers and the datapath where a full-width single-cycle carry chain is too slow or too large.

## Interface
- WIDTH, 64: operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 16: bits processed per cycle. N = WIDTH/CHUNK beats per operation; CHUNK = WIDTH gives N = 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  WIDTH  operand, interpreted as two's complement.
- in_op  in  2  mode: 00 pass, 01 negate (~x+1), 10 absolute value, 11 ones' complement (~x).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_ovf  out  1  overflow flag; set only when negate or abs is applied to the most negative value 1<<(WIDTH-1).

## Operation
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_data and in_op, clear the beat counter, and go to CALC.
  - Latch inv = (op==01) | (op==11) | (op==10 & in_data[WIDTH-1]).
  - Latch carry0 = (op==01) | (op==10 & in_data[WIDTH-1]).
- CALC, beat k = 0..N-1, processing bits [k*CHUNK +: CHUNK]:
  - slice = (inv ? ~d_slice : d_slice) + carry.
  - Write the low CHUNK bits of slice into the result register. Store the carry-out for the next beat.
  - Beat 0 uses carry0. The carry-out of beat N-1 is discarded.
  - After beat N-1, go to DONE.
- DONE:
  - out_valid=1. out_data and out_ovf stay stable until out_ready.
  - On out_valid&out_ready, go to IDLE.
- out_ovf = carry0 & (operand == 1<<(WIDTH-1)). In that case out_data equals the operand (wraps to itself).
- Negating 0 gives 0 with out_ovf=0; the final carry-out is discarded silently.
- Abs of a non-negative operand is pass-through. Pass and ones'-complement modes never set out_ovf.
- in_data and in_op are ignored outside the accepting IDLE cycle. Changes during CALC or DONE have no effect.
- Only one operation is in flight; there is no input buffering.

## Timing
- Reset values: state=IDLE, in_ready=1 (IDLE), out_valid=0, out_data=0, out_ovf=0, beat counter=0, carry=0.
- rst asserted during CALC or DONE:
  - The operation is discarded and all reset values apply on the next edge.
  - The result is never presented. out_valid drops at that edge even if out_ready was low.
- Latency:
  - Accept edge T. CALC beats occur at edges T+1..T+N.
  - out_valid is high from edge T+N; first visible in cycle N after acceptance.
- Throughput: at most one operation per N+2 cycles (accept, N beats, DONE handshake). in_ready rises the cycle after the output handshake.
- Backpressure: with out_ready low, DONE holds indefinitely and in_ready stays 0.
- in_valid during DONE is not accepted, even in the cycle that out_ready is high.
- N=1: behaves identically with a single CALC beat.

## Test plan
- WIDTH=64, CHUNK=16, op=01, in_data=0x0000_0000_0000_0001 → out_valid exactly 4 cycles after the accept edge, out_data=0xFFFF_FFFF_FFFF_FFFF, out_ovf=0.
- op=01, in_data=0x0000_0000_0001_0000 → 0xFFFF_FFFF_FFFF_0000. Checks carry ripple across slice boundaries. Then in_data=0 → 0, out_ovf=0.
- op=01 and op=10, in_data=0x8000_0000_0000_0000 → out_data=0x8000_0000_0000_0000, out_ovf=1. op=11 with the same operand → 0x7FFF_FFFF_FFFF_FFFF, out_ovf=0.
- op=10, in_data=0xFFFF_FFFF_FFFF_FFFB → 0x0000_0000_0000_0005. op=10, in_data=0x5 → 0x5. op=00 with random data → unchanged.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_data stable and in_ready=0 throughout. Assert rst mid-CALC (beat 2) → next cycle out_valid=0, out_data=0, in_ready=1, and no result is ever emitted.
- Random regression:
  - 1000 random 64-bit operands with op=01 against model ~x+1, as in the predecessor bench.
  - Rerun with CHUNK=64 and CHUNK=8, and with WIDTH=32, CHUNK=8.
  - Randomly toggle in_valid and out_ready; every accepted operand yields exactly one correct result, in order.
